// File: rtl/nibble_serial_add_seq.sv
// rtl/nibble_serial_add_seq.sv - drives one external 4-bit adder stage nibble by nibble to add NIBBLES*4-bit operands
// Optional subtract mode (sub port) enabled by defining ADD_SEQ_SUB_EN.
module nibble_serial_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  result_q;
  logic          cout_q;
  logic          ovf_q;

  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic          last_nibble;
  logic [W-1:0]  b_load;
  logic          cin_load;

  assign in_ready    = (state == ST_IDLE);
  assign out_valid   = (state == ST_DONE);
  assign out_sum     = result_q;
  assign out_cout    = cout_q;
  assign out_ovf     = ovf_q;
  assign last_nibble = (idx == IW'(NIBBLES - 1));

`ifdef ADD_SEQ_SUB_EN
  // Subtraction is A + ~B + 1; the inverted B also feeds the overflow test.
  assign b_load   = sub ? ~in_b : in_b;
  assign cin_load = sub ? 1'b1 : in_cin;
`else
  assign b_load   = in_b;
  assign cin_load = in_cin;
`endif

  always_comb begin
    a_sh    = a_q >> {idx, 2'b00};
    b_sh    = b_q >> {idx, 2'b00};
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == ST_RUN) begin
      add_a   = a_sh[3:0];
      add_b   = b_sh[3:0];
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= b_load;
            carry_q <= cin_load;
            idx     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_q[{idx, 2'b00} +: 4] <= add_sum;
          carry_q                     <= add_cout;
          if (last_nibble) begin
            cout_q <= add_cout;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
            idx    <= '0;
            state  <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// tb/tb_nibble_serial_add_seq.sv - directed self-checking bench for nibble_serial_add_seq (NIBBLES=4)
// Subtract tests are compiled in when ADD_SEQ_SUB_EN is defined.
module tb_nibble_serial_add_seq;

  localparam int NIB = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
`ifdef ADD_SEQ_SUB_EN
  logic        sub;
`endif
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int checks;
  int errors;

  logic [15:0] seq_a;
  logic [15:0] seq_b;
  logic [3:0]  seq_cin;
  logic        early_valid;

  // External 4-bit adder stage
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_serial_add_seq #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: in_ready=%b expected 1", in_ready);
    end
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Records the adder-stage drive for each RUN cycle, then leaves the bench one cycle into DONE.
  task automatic run_op();
    early_valid = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      seq_a[4*i +: 4] = add_a;
      seq_b[4*i +: 4] = add_b;
      seq_cin[i]      = add_cin;
      if (out_valid) early_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (early_valid !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: early_valid=%b out_valid=%b expected 0/1", early_valid, out_valid);
    end
  endtask

  task automatic check_result(input string name, input logic [15:0] es, input logic ec, input logic eo);
    checks++;
    if (out_sum !== es || out_cout !== ec || out_ovf !== eo) begin
      errors++;
      $display("FAIL %s: sum=%h cout=%b ovf=%b expected %h/%b/%b", name, out_sum, out_cout, out_ovf, es, ec, eo);
    end
  endtask

  task automatic finish_op();
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL return_idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: rdy=%b vld=%b sum=%h cout=%b ovf=%b expected 1/0/0000/0/0",
               in_ready, out_valid, out_sum, out_cout, out_ovf);
    end
    checks++;
    if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_add: add_a=%h add_b=%h add_cin=%b expected 0/0/0", add_a, add_b, add_cin);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    start_op(16'h1234, 16'h4321, 1'b0);
    run_op();
    check_result("basic", 16'h5555, 1'b0, 1'b0);
    checks++;
    if (seq_a !== 16'h1234 || seq_b !== 16'h4321 || seq_cin !== 4'b0000) begin
      errors++;
      $display("FAIL basic_seq: seq_a=%h seq_b=%h seq_cin=%b expected 1234/4321/0000", seq_a, seq_b, seq_cin);
    end
    checks++;
    if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL done_add_zero: add_a=%h add_b=%h add_cin=%b expected 0/0/0", add_a, add_b, add_cin);
    end
    finish_op();
  endtask

  task automatic test_carry();
    start_op(16'hFFFF, 16'h0001, 1'b0);
    run_op();
    check_result("carry_wrap", 16'h0000, 1'b1, 1'b0);
    checks++;
    if (seq_cin !== 4'b1110) begin
      errors++;
      $display("FAIL carry_seq: seq_cin=%b expected 1110", seq_cin);
    end
    finish_op();
    start_op(16'h00FF, 16'h0000, 1'b1);
    run_op();
    check_result("cin_in", 16'h0100, 1'b0, 1'b0);
    finish_op();
  endtask

  task automatic test_overflow();
    start_op(16'h7FFF, 16'h0001, 1'b0);
    run_op();
    check_result("ovf_pos", 16'h8000, 1'b0, 1'b1);
    finish_op();
    start_op(16'h8000, 16'h8000, 1'b0);
    run_op();
    check_result("ovf_neg", 16'h0000, 1'b1, 1'b1);
    finish_op();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    start_op(16'h1234, 16'h4321, 1'b0);
    run_op();
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'h5555 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: vld=%b rdy=%b sum=%h cout=%b ovf=%b expected 1/0/5555/0/0",
                 i, out_valid, in_ready, out_sum, out_cout, out_ovf);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_op();
    start_op(16'h0003, 16'h0004, 1'b1);
    run_op();
    check_result("after_bp", 16'h0008, 1'b0, 1'b0);
    finish_op();
  endtask

  task automatic test_reset_mid();
    start_op(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (add_a !== 4'h1 || add_b !== 4'h2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_run: add_a=%h add_b=%h rdy=%b expected 1/2/0", add_a, add_b, in_ready);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || add_a !== 4'h0 || out_sum !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b vld=%b add_a=%h sum=%h expected 1/0/0/0000", in_ready, out_valid, add_a, out_sum);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_stale_valid: out_valid=%b expected 0", out_valid);
    end
    start_op(16'h0001, 16'h0001, 1'b0);
    run_op();
    check_result("after_reset", 16'h0002, 1'b0, 1'b0);
    finish_op();
  endtask

`ifdef ADD_SEQ_SUB_EN
  task automatic test_sub();
    sub = 1'b1;
    start_op(16'h0005, 16'h0007, 1'b0);
    run_op();
    check_result("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
    finish_op();
    start_op(16'h0007, 16'h0005, 1'b0);
    run_op();
    check_result("sub_noborrow", 16'h0002, 1'b1, 1'b0);
    finish_op();
    sub = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
`ifdef ADD_SEQ_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_backpressure();
    test_reset_mid();
`ifdef ADD_SEQ_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_seq.md
Name: nibble_serial_add_seq

Overview:
Multi-cycle sequencer that adds two NIBBLES×4-bit operands by driving one external 4-bit ripple adder stage, one nibble per cycle, LSB nibble first. It sits directly upstream of the 4-bit adder: it feeds that stage's a/b/cin inputs and consumes its sum/cout outputs. Operands arrive and results leave over valid/ready handshakes.

Parameters:
NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES); legal range 1..16.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand transfer request
in_ready  output  1  sequencer can accept operands
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  initial carry-in
add_a  output  4  nibble of A to the adder stage
add_b  output  4  nibble of B to the adder stage
add_cin  output  1  carry to the adder stage
add_sum  input  4  sum from the adder stage (combinational from add_a/add_b/add_cin)
add_cout  input  1  carry-out from the adder stage
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  W  full sum
out_cout  output  1  final carry-out
out_ovf  output  1  signed overflow

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE, nibble index 0, carry_q 0, operand and result registers 0.
- Reset output values: in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, add_a=0, add_b=0, add_cin=0.
- in_ready = (state==IDLE). out_valid = (state==DONE). There are no combinational paths from in_valid to in_ready or from out_ready to out_valid.
- IDLE: when in_valid is high, latch in_a, in_b, and carry_q<=in_cin; set idx<=0; go to RUN.
- RUN, cycle idx: add_a=A[4*idx+:4], add_b=B[4*idx+:4], add_cin=carry_q. On the edge: result[4*idx+:4]<=add_sum, carry_q<=add_cout, idx<=idx+1.
  - When idx==NIBBLES-1, also capture out_cout<=add_cout and out_ovf<=(A[W-1]==B[W-1]) && (add_sum[3]!=A[W-1]), then go to DONE.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- Latency: handshake accepted at edge T; out_valid rises after edge T+NIBBLES; NIBBLES+1 cycles from acceptance to result.
- DONE: out_sum, out_cout and out_ovf are held stable while out_valid=1 and out_ready=0, for any number of cycles. out_ready=1 returns to IDLE on that edge. Earliest next acceptance is one cycle later, so throughput is 1 op per NIBBLES+2 cycles.
- in_valid in RUN or DONE is ignored (in_ready=0). Operand registers are not altered while busy.
- NIBBLES=1: RUN lasts exactly one cycle.
- Carry wrap: out_sum is modulo 2^W. The carry leaves only via out_cout.
- Reset mid-operation (RUN or DONE): the operation is discarded and reset values apply immediately (asynchronous). No out_valid is produced for that operation.
- idx is ceil(log2(NIBBLES+1)) bits wide and never exceeds NIBBLES-1 in RUN.

Optional Feature:
Macro ADD_SEQ_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with the operands at acceptance and held for the operation.
- sub=1: B is latched inverted (~in_b) and carry_q<=1, regardless of in_cin. out_cout=1 means no borrow (A>=B unsigned). out_ovf uses the inverted B.
- sub=0: behaviour is identical to the macro-undefined build.
- Undefined: no sub port; addition only.

Test Plan:
- NIBBLES=4: A=0x1234, B=0x4321, cin=0, out_ready=1 -> out_valid 5 cycles after accept; out_sum=0x5555, cout=0, ovf=0. add_a sequence 4,3,2,1.
- A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x0000, cout=1, ovf=0. add_cin sequence 0,1,1,1.
- A=0x7FFF, B=0x0001, cin=0 -> 0x8000, cout=0, ovf=1. Then A=0x8000, B=0x8000 -> 0x0000, cout=1, ovf=1.
- Backpressure: out_ready=0 for 10 cycles after result 0x5555 -> outputs stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> IDLE next cycle; the following op accepts.
- Assert reset during RUN idx 2 -> in_ready=1 and out_valid=0 immediately. A subsequent op 0x0001+0x0001 yields 0x0002.
- ADD_SEQ_SUB_EN defined: A=0x0005, B=0x0007, sub=1 -> out_sum=0xFFFE, cout=0. A=0x0007, B=0x0005, sub=1 -> 0x0002, cout=1.
